// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the multiport register file.
package rf_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int ZERO_REG   = 0;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: write, allocate and read-port bundle of the register file.
interface regfile_multiport_if import rf_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [XLEN-1:0]          wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [XLEN-1:0]          wdata1;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*XLEN-1:0]   rdata;
    logic [NUM_RD-1:0]        rbusy;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, alloc_en, alloc_addr, raddr,
        input  rdata, rbusy
    );
    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, alloc_en, alloc_addr, raddr,
        output rdata, rbusy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per register; writes clear, allocation sets (set wins).
module rf_scoreboard import rf_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr,
    output logic [depth(ADDR_W)-1:0]   busy
);
    localparam int DEPTH = depth(ADDR_W);
    logic [DEPTH-1:0] clr, set, nxt;

    // register 0 is never a real destination, so its bit is masked off
    assign clr = (DEPTH'(we0) << waddr0) | (DEPTH'(we1) << waddr1);
    assign set = DEPTH'(alloc_en) << alloc_addr;
    assign nxt = ((busy & ~clr) | set) & ~(DEPTH'(1) << ZERO_REG);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else        busy <= nxt;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: dual-write, NUM_RD-read register file with busy scoreboard.
// RF_BYPASS_EN: forwards same-cycle write data to matching read ports.
module regfile_multiport import rf_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input logic                clk,
    input logic                rst_n,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] busy;

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .we0        (bus.we0),
        .waddr0     (bus.waddr0),
        .we1        (bus.we1),
        .waddr1     (bus.waddr1),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .busy       (busy)
    );

    // port 1 is written last so it wins a same-address collision
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (bus.we0 && bus.waddr0 != ZERO) mem[bus.waddr0] <= bus.wdata0;
            if (bus.we1 && bus.waddr1 != ZERO) mem[bus.waddr1] <= bus.wdata1;
        end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [XLEN-1:0]   stored;
        assign a      = bus.raddr[k*ADDR_W +: ADDR_W];
        assign stored = a == ZERO ? '0 : mem[a];
`ifdef RF_BYPASS_EN
        logic h0, h1, ha;
        assign h0 = rst_n && a != ZERO && bus.we0 && bus.waddr0 == a;
        assign h1 = rst_n && a != ZERO && bus.we1 && bus.waddr1 == a;
        assign ha = bus.alloc_en && bus.alloc_addr == a;
        assign bus.rdata[k*XLEN +: XLEN] = h1 ? bus.wdata1 : h0 ? bus.wdata0 : stored;
        assign bus.rbusy[k] = (h0 || h1) ? ha : busy[a];
`else
        assign bus.rdata[k*XLEN +: XLEN] = stored;
        assign bus.rbusy[k] = busy[a];
`endif
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed test with a behavioural model checked every cycle.
module tb_regfile_multiport;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) b ();
    regfile_multiport_if #(.XLEN(64), .ADDR_W(4), .NUM_RD(3)) w ();

    regfile_multiport #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    regfile_multiport #(.XLEN(64), .ADDR_W(4), .NUM_RD(3)) dut_w (.clk(clk), .rst_n(rst_n), .bus(w));

    logic [31:0] m [32];
    logic        bz [32];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m[i]  <= '0;
                bz[i] <= 1'b0;
            end
        end else begin
            if (b.we0 && b.waddr0 != 0) m[b.waddr0] <= b.wdata0;
            if (b.we1 && b.waddr1 != 0) m[b.waddr1] <= b.wdata1;
            if (b.we0) bz[b.waddr0] <= 1'b0;
            if (b.we1) bz[b.waddr1] <= 1'b0;
            if (b.alloc_en && b.alloc_addr != 0) bz[b.alloc_addr] <= 1'b1;
        end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0]  a;
            logic [31:0] ed;
            logic        eb;
            a  = b.raddr[k*5 +: 5];
            ed = (a == 0) ? 32'd0 : m[a];
            eb = (a == 0) ? 1'b0 : bz[a];
            if (BYP && rst_n && a != 0 && ((b.we0 && b.waddr0 == a) || (b.we1 && b.waddr1 == a))) begin
                ed = (b.we1 && b.waddr1 == a) ? b.wdata1 : b.wdata0;
                eb = b.alloc_en && b.alloc_addr == a;
            end
            if (!rst_n) begin
                ed = '0;
                eb = 1'b0;
            end
            checks++;
            if (b.rdata[k*32 +: 32] !== ed || b.rbusy[k] !== eb) begin
                failures++;
                $display("FAIL model port%0d addr=%0d got data=%h busy=%b want data=%h busy=%b @%0t",
                         k, a, b.rdata[k*32 +: 32], b.rbusy[k], ed, eb, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.we0 = 0; b.we1 = 0; b.alloc_en = 0;
        w.we0 = 0; w.we1 = 0; w.alloc_en = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        b.raddr = {a1, a0};
    endtask

    initial begin
        idle();
        b.waddr0 = 0; b.wdata0 = 0; b.waddr1 = 0; b.wdata1 = 0; b.alloc_addr = 0; b.raddr = 0;
        w.waddr0 = 0; w.wdata0 = 0; w.waddr1 = 0; w.wdata1 = 0; w.alloc_addr = 0; w.raddr = 0;
        step(); step();
        chk("reset_rdata", {32'd0, b.rdata}, 64'd0);
        chk("reset_rbusy", {62'd0, b.rbusy}, 64'd0);
        chk("reset_wide_rbusy", {61'd0, w.rbusy}, 64'd0);
        rst_n = 1;
        step();
        // reset mid-write
        b.we0 = 1; b.waddr0 = 3; b.wdata0 = 32'hAA; rd(3, 3);
        step();
        chk("pre_reset_addr3", {32'd0, b.rdata[31:0]}, 64'hAA);
        #1 rst_n = 0;
        #1 chk("async_reset_addr3", {32'd0, b.rdata[31:0]}, 64'd0);
        b.we0 = 0;
        step();
        rst_n = 1;
        step();
        chk("post_reset_addr3", {32'd0, b.rdata[31:0]}, 64'd0);
        // basic write/read
        b.we0 = 1; b.waddr0 = 1; b.wdata0 = 8;
        step(); idle();
        b.we1 = 1; b.waddr1 = 2; b.wdata1 = 6;
        step(); idle();
        rd(2, 1);
        #1 chk("read_p0_addr2", {32'd0, b.rdata[31:0]}, 64'd6);
        chk("read_p1_addr1", {32'd0, b.rdata[63:32]}, 64'd8);
        b.we0 = 1; b.waddr0 = 0; b.wdata0 = 32'h55; rd(0, 0);
        step(); idle();
        chk("addr0_reads_zero", {32'd0, b.rdata[31:0]}, 64'd0);
        // write collision then distinct addresses
        b.we0 = 1; b.waddr0 = 31; b.wdata0 = 156;
        b.we1 = 1; b.waddr1 = 31; b.wdata1 = 674;
        step(); idle();
        rd(31, 30);
        #1 chk("collision_p1_wins", {32'd0, b.rdata[31:0]}, 64'd674);
        b.we0 = 1; b.waddr0 = 30; b.wdata0 = 156;
        b.we1 = 1; b.waddr1 = 31; b.wdata1 = 674;
        step(); idle();
        chk("distinct_addr30", {32'd0, b.rdata[63:32]}, 64'd156);
        chk("distinct_addr31", {32'd0, b.rdata[31:0]}, 64'd674);
        // scoreboard
        b.alloc_en = 1; b.alloc_addr = 5; rd(5, 0);
        #1 chk("alloc_not_yet_busy", {63'd0, b.rbusy[0]}, 64'd0);
        step(); idle();
        chk("alloc_busy", {63'd0, b.rbusy[0]}, 64'd1);
        b.we0 = 1; b.waddr0 = 5; b.wdata0 = 9;
        step(); idle();
        chk("write_clears_busy", {63'd0, b.rbusy[0]}, 64'd0);
        chk("write_data_addr5", {32'd0, b.rdata[31:0]}, 64'd9);
        b.alloc_en = 1; b.alloc_addr = 5; b.we1 = 1; b.waddr1 = 5; b.wdata1 = 11;
        step(); idle();
        chk("alloc_wins_over_clear", {63'd0, b.rbusy[0]}, 64'd1);
        chk("alloc_write_data", {32'd0, b.rdata[31:0]}, 64'd11);
        b.alloc_en = 1; b.alloc_addr = 5;
        step(); idle();
        chk("realloc_stays_busy", {63'd0, b.rbusy[0]}, 64'd1);
        b.alloc_en = 1; b.alloc_addr = 0; rd(0, 5);
        step(); idle();
        chk("alloc_addr0_ignored", {63'd0, b.rbusy[0]}, 64'd0);
        // bypass behaviour
        b.we0 = 1; b.waddr0 = 7; b.wdata0 = 32'h10;
        step(); idle();
        b.we0 = 1; b.waddr0 = 7; b.wdata0 = 32'h20; rd(7, 7);
        #1 chk("same_cycle_read", {32'd0, b.rdata[31:0]}, BYP ? 64'h20 : 64'h10);
        chk("same_cycle_busy", {63'd0, b.rbusy[0]}, 64'd0);
        step(); idle();
        chk("after_edge_read", {32'd0, b.rdata[31:0]}, 64'h20);
        // wide instance
        w.we0 = 1; w.waddr0 = 15; w.wdata0 = 64'hFFFF_0000_1234_5678; w.raddr = {4'd15, 4'd15, 4'd15};
        step(); idle();
        chk("wide_p0", w.rdata[63:0], 64'hFFFF_0000_1234_5678);
        chk("wide_p1", w.rdata[127:64], 64'hFFFF_0000_1234_5678);
        chk("wide_p2", w.rdata[191:128], 64'hFFFF_0000_1234_5678);
        w.we0 = 1; w.waddr0 = 4'(5'd16); w.wdata0 = 64'hDEAD; w.raddr = '0;
        step(); idle();
        chk("wide_alias_addr0", w.rdata[63:0], 64'd0);
        w.raddr = {4'd15, 4'd0, 4'd15};
        #1 chk("wide_addr15_kept", w.rdata[191:128], 64'hFFFF_0000_1234_5678);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Configurable data width, depth and read-port count.
- Two write ports with a fixed priority rule; register 0 hardwired to zero.
- Per-register busy scoreboard for the pipelined core: decode allocates a destination, writeback releases it, and read ports report operand readiness.

Parameters:
- XLEN, 32, data width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  XLEN  write data, port 1
- alloc_en  in  1  mark destination busy
- alloc_addr  in  ADDR_W  destination to mark busy
- raddr  in  NUM_RD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*XLEN  read data, packed the same way
- rbusy  out  NUM_RD  1 = addressed register has a pending write

Behaviour:
Reset:
- Clock and reset are one clock, asynchronous active-low reset.
- rst_n low clears all registers to 0 and all busy bits to 0 immediately, independent of clk.
- While in reset, rdata = 0 and rbusy = 0.
- Reset deassertion is synchronised externally; the block treats rst_n as clean.

Writes:
- Writes are synchronous on the rising edge.
- Writes to address 0 are ignored on both ports.
- we0 and we1 targeting the same address in the same cycle: port 1 data is stored and port 0 is dropped.
- Different addresses: both are stored.

Reads:
- Combinational, zero-latency.
- Address 0 always returns 0 with rbusy = 0.
- Without bypass, a read of an address written this cycle returns the old value until after the edge.

Scoreboard:
- Edge-triggered, one bit per register.
- alloc_en sets busy[alloc_addr]; alloc to address 0 is ignored.
- Any enabled write clears busy[waddr].
- Simultaneous alloc and write to the same address: set wins, since the new producer supersedes the old one.
- Allocating an already-busy register leaves it busy (no count; single outstanding producer per register).
- rbusy[k] = busy[raddr[k]], combinational.

Ordering:
- Per edge, apply writes (port 0 then port 1) first, then scoreboard clear, then set.

Widths:
- No arithmetic; all addresses are used modulo depth (natural truncation).

Optional Feature:
RF_BYPASS_EN:
- When defined, a read port whose address matches an enabled write this cycle (address non-zero) returns that write data combinationally.
- If both write ports match, port 1 data is returned.
- rbusy for that port is forced to 0 unless alloc_en targets the same address in the same cycle.
- When undefined, reads see only stored state; the bypass muxes are absent.

Decomposition:
- Package rf_pkg holds:
  - default constants XLEN_DEF = 32, ADDR_W_DEF = 5, NUM_RD_DEF = 2
  - ZERO_REG = 0
  - localparam function for depth
- Sub-module rf_scoreboard:
  - holds the busy vector
  - takes alloc/write strobes
  - exports the full busy vector
- The data array and read/bypass muxing stay in regfile_multiport.

Test Plan:
1. Reset mid-write: we0 = 1, waddr0 = 3, wdata0 = 0xAA, assert rst_n low between edges -> rdata for addr 3 = 0 immediately; after release with no write, still 0.
2. Basic write/read: we0 writes 8 to addr 1, then we1 writes 6 to addr 2; raddr = {2,1} -> rdata port0 = 6, port1 = 8 combinationally; write 0x55 to addr 0 -> reads 0.
3. Write collision: we0 (addr 31, 156) and we1 (addr 31, 674) same edge -> addr 31 reads 674; distinct addrs 30/31 with 156/674 -> both stored.
4. Scoreboard:
   - alloc addr 5 -> rbusy = 1 from next cycle.
   - write addr 5 -> rbusy = 0 after edge.
   - alloc + write addr 5 same edge -> rbusy stays 1.
   - alloc addr 0 -> rbusy = 0.
5. Bypass (RF_BYPASS_EN defined): addr 7 holds 0x10; same cycle we0 writes 0x20 to 7 with raddr = 7 -> rdata = 0x20, rbusy = 0 before the edge. Without the macro -> rdata = 0x10 until the edge.
6. Parameter sweep: XLEN = 64, ADDR_W = 4, NUM_RD = 3 -> write 0xFFFF_0000_1234_5678 to addr 15 and read on all three ports; addr 16 write aliases to addr 0 and is ignored.
